mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory slave with a fixed access latency and a one-cycle completion strobe.
// Misaligned, out-of-range or read+write requests complete with addr_err and leave storage untouched.
module mem_responder #(
    parameter int WORDS_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic                  ld_en,
    input  logic [WORDS_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic [31:0]           rdata,
    output logic                  mem_ready,
    output logic                  addr_err,
    output logic                  busy
);

    localparam int         WORDS    = 1 << WORDS_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  op_write;
    logic                  op_err;
    logic [WORDS_LOG2-1:0] op_idx;
    logic [31:0]           op_wdata;

    logic [31:0]           mem [WORDS];

    logic                  request;
    logic                  req_err;
    logic                  mem_we;
    logic [WORDS_LOG2-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    assign request = mem_read | mem_write;
    assign req_err = (addr[1:0] != 2'b00)
                  || ((addr >> (WORDS_LOG2 + 2)) != 32'd0)
                  || (mem_read && mem_write);

    // The access write lands on the edge that enters RESP; preload only when idle with no request.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        mem_we    = 1'b0;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
        if (reset) begin
            if (state == BUSY && cnt == 4'd0 && op_write && !op_err) begin
                mem_we    = 1'b1;
                mem_waddr = op_idx;
                mem_wdata = op_wdata;
            end else if (state == IDLE && !request && ld_en) begin
                mem_we = 1'b1;
            end
        end
    end

    // NOTE: storage has no reset so it maps onto RAM and keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rdata     <= 32'd0;
            addr_err  <= 1'b0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            op_write  <= 1'b0;
            op_err    <= 1'b0;
            op_idx    <= '0;
            op_wdata  <= 32'd0;
        end else begin
            mem_ready <= 1'b0;
            addr_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        state    <= BUSY;
                        busy     <= 1'b1;
                        cnt      <= CNT_INIT;
                        op_write <= mem_write;
                        op_err   <= req_err;
                        op_idx   <= addr[WORDS_LOG2+1:2];
                        op_wdata <= wdata;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        addr_err  <= op_err;
                        if (!op_err && !op_write) begin
                            rdata <= mem[op_idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
